// File: rtl/hog_result_wr_ctrl.sv
// hog_result_wr_ctrl: writes one HOG feature frame from the reader into DDR
// as fixed-length AXI4 INCR bursts, pacing the reader one beat at a time.
module hog_result_wr_ctrl #(
  parameter int AXI_AW = 32,
  parameter int AXI_DW = 512,
  parameter int BURST_LEN = 16,
  parameter int TOTAL_BEATS = 1984
) (
  input  logic                aclk,
  input  logic                arest,
  input  logic                start,
  input  logic [AXI_AW-1:0]   base_addr,
  output logic                res_start,
  output logic                w_handshake,
  input  logic [AXI_DW-1:0]   res_data,
  input  logic                res_data_valid,
  output logic                wr_done,
  output logic                busy,
  output logic [1:0]          err,
  output logic [AXI_AW-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [AXI_DW-1:0]   m_axi_wdata,
  output logic [AXI_DW/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready
);
  localparam int NBURST = TOTAL_BEATS / BURST_LEN;
  localparam int BIW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
  localparam int NBW = NBURST > 1 ? $clog2(NBURST) : 1;
  localparam logic [AXI_AW-1:0] STRIDE = AXI_AW'(BURST_LEN * 64);

  typedef enum logic [2:0] {IDLE, AW, W, B, DONE} state_t;

  state_t            state, state_d;
  logic [AXI_AW-1:0] base_q;
  logic [NBW-1:0]    burst_idx;
  logic [BIW-1:0]    beat_idx;
  logic [AXI_DW-1:0] hold_data;
  logic              hold_full;
  logic              w_acc, last_beat, last_burst, load, ovr, b_acc, go;

  assign m_axi_awlen   = 8'(BURST_LEN - 1);
  assign m_axi_awsize  = 3'd6;
  assign m_axi_awburst = 2'b01;
  assign m_axi_wstrb   = '1;
  assign m_axi_awaddr  = base_q + AXI_AW'(burst_idx) * STRIDE;
  assign m_axi_awvalid = state == AW;
  assign m_axi_wvalid  = state == W && hold_full;
  assign m_axi_wdata   = hold_data;
  assign m_axi_wlast   = m_axi_wvalid && last_beat;
  assign m_axi_bready  = state == B;
  assign busy          = state != IDLE;
  assign wr_done       = state == DONE;
  assign go            = state == IDLE && start;
  assign w_acc         = m_axi_wvalid && m_axi_wready;
  assign b_acc         = state == B && m_axi_bvalid;
  assign last_beat     = beat_idx == BIW'(BURST_LEN - 1);
  assign last_burst    = burst_idx == NBW'(NBURST - 1);
  // A beat may refill the holding register in the same cycle it drains.
  assign load          = res_data_valid && (!hold_full || w_acc);
  assign ovr           = res_data_valid && hold_full && !w_acc;

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    state_d = start ? AW : IDLE;
      AW:      state_d = m_axi_awready ? W : AW;
      W:       state_d = w_acc && last_beat ? B : W;
      B:       state_d = m_axi_bvalid ? (last_burst ? DONE : AW) : B;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge arest) begin
    if (arest) begin
      state       <= IDLE;
      base_q      <= '0;
      burst_idx   <= '0;
      beat_idx    <= '0;
      hold_data   <= '0;
      hold_full   <= 1'b0;
      err         <= 2'b00;
      res_start   <= 1'b0;
      w_handshake <= 1'b0;
    end else begin
      state       <= state_d;
      res_start   <= go;
      w_handshake <= w_acc;
      if (go) begin
        base_q    <= {base_addr[AXI_AW-1:10], 10'b0};
        burst_idx <= '0;
        beat_idx  <= '0;
        hold_full <= 1'b0;
        err       <= 2'b00;
      end else begin
        if (load) hold_data <= res_data;
        hold_full <= load || (hold_full && !w_acc);
        if (w_acc) beat_idx <= last_beat ? '0 : beat_idx + 1'b1;
        if (b_acc && !last_burst) burst_idx <= burst_idx + 1'b1;
        err <= err | {ovr, b_acc && m_axi_bresp != 2'b00};
      end
    end
  end
endmodule

// File: tb/tb_hog_result_wr_ctrl.sv
// tb_hog_result_wr_ctrl: directed frame writes with a latency-3 reader model,
// W stall, overrun injection, bad bresp, ignored restart and mid-frame reset.
module tb_hog_result_wr_ctrl;
  localparam int TOTAL = 1984;
  localparam int BL = 16;
  localparam int NBURST = 124;

  logic         aclk = 0;
  logic         arest = 0;
  logic         start = 0;
  logic [31:0]  base_addr = 0;
  logic         res_start, w_handshake, wr_done, busy;
  logic [511:0] res_data = 0;
  logic         res_data_valid = 0;
  logic [1:0]   err;
  logic [31:0]  m_axi_awaddr;
  logic [7:0]   m_axi_awlen;
  logic [2:0]   m_axi_awsize;
  logic [1:0]   m_axi_awburst;
  logic         m_axi_awvalid;
  logic         m_axi_awready = 1;
  logic [511:0] m_axi_wdata;
  logic [63:0]  m_axi_wstrb;
  logic         m_axi_wlast, m_axi_wvalid;
  logic         m_axi_wready = 1;
  logic [1:0]   m_axi_bresp = 0;
  logic         m_axi_bvalid = 1;
  logic         m_axi_bready;

  hog_result_wr_ctrl dut (
    .aclk(aclk), .arest(arest), .start(start), .base_addr(base_addr),
    .res_start(res_start), .w_handshake(w_handshake), .res_data(res_data),
    .res_data_valid(res_data_valid), .wr_done(wr_done), .busy(busy), .err(err),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  always #5 aclk = ~aclk;

  int checks = 0, failures = 0;
  int cd, nsent, ntrig, naw, nw, nlast, nb, ndone, nhs, aw_bad, w_bad;
  int stall_beat = -1, stall_left = 0, bad_burst = -1;
  bit inject = 0, injected, inj_prev, stalling, start_req = 0;
  logic [31:0] start_base = 0, exp_base = 0, first_aw;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] pat(input int n);
    logic [31:0] w;
    w = 32'(n) * 32'h9E37_79B9 + 32'h0BAD_F00D;
    return {16{w}};
  endfunction

  task automatic clear_counters();
    naw = 0; nw = 0; nlast = 0; nb = 0; ndone = 0; nhs = 0; aw_bad = 0; w_bad = 0;
    first_aw = 0; injected = 0; inj_prev = 0; stalling = 0;
    cd = 0; nsent = 0; ntrig = 0;
  endtask

  // Drive just after the edge, observe at the falling edge.
  task automatic cycle();
    @(posedge aclk);
    #1;
    start = start_req;
    base_addr = start_base;
    start_req = 0;
    res_data_valid = 0;
    if (cd != 0) begin
      cd--;
      if (cd == 0) begin
        res_data_valid = 1;
        res_data = pat(nsent);
        nsent++;
      end
    end
    if ((res_start || w_handshake) && ntrig < TOTAL) begin
      cd = 3;
      ntrig++;
    end
    stalling = m_axi_wvalid && nw == stall_beat && stall_left > 0;
    if (stalling) stall_left--;
    m_axi_wready = !stalling;
    if (stalling && inject && stall_left == 2) begin
      res_data_valid = 1;
      res_data = {16{32'hDEAD_BEEF}};
      injected = 1;
    end
    m_axi_bresp = (nb == bad_burst) ? 2'b10 : 2'b00;
    @(negedge aclk);
    if (m_axi_awvalid && m_axi_awready) begin
      if (naw == 0) first_aw = m_axi_awaddr;
      if (m_axi_awaddr !== exp_base + 32'(naw) * 32'h400) aw_bad++;
      naw++;
    end
    if (m_axi_wvalid && m_axi_wready) begin
      if (m_axi_wdata !== pat(nw) || m_axi_wlast !== (nw % BL == BL - 1)) w_bad++;
      if (m_axi_wlast) nlast++;
      nw++;
    end
    if (m_axi_bvalid && m_axi_bready) nb++;
    if (wr_done) ndone++;
    if (w_handshake) nhs++;
    if (stalling) begin
      check("stall_wvalid", m_axi_wvalid, 1);
      check("stall_wdata", m_axi_wdata, pat(stall_beat));
      check("stall_no_hs", w_handshake, 0);
      check("stall_err1", err[1], inj_prev);
    end
    inj_prev = injected;
  endtask

  task automatic run_frame(input logic [31:0] base, input logic [31:0] expb);
    start_base = base;
    exp_base = expb;
    start_req = 1;
    for (int i = 0; i < 20000 && ndone == 0; i++) cycle();
    repeat (5) cycle();
  endtask

  task automatic frame_checks(input string f, input logic [1:0] exp_err);
    check({f, "_aw_cnt"}, naw, NBURST);
    check({f, "_aw_addr_bad"}, aw_bad, 0);
    check({f, "_w_cnt"}, nw, TOTAL);
    check({f, "_w_bad"}, w_bad, 0);
    check({f, "_wlast_cnt"}, nlast, NBURST);
    check({f, "_b_cnt"}, nb, NBURST);
    check({f, "_hs_cnt"}, nhs, TOTAL);
    check({f, "_done_cnt"}, ndone, 1);
    check({f, "_err"}, err, exp_err);
    check({f, "_idle"}, busy, 0);
  endtask

  initial begin
    clear_counters();
    #2 arest = 1;
    #1;
    check("rst_outputs", {res_start, w_handshake, wr_done, busy, m_axi_awvalid,
                          m_axi_wvalid, m_axi_wlast, m_axi_bready, err}, 0);
    check("rst_wdata", m_axi_wdata, 0);
    check("awlen", m_axi_awlen, 15);
    check("awsize", m_axi_awsize, 6);
    check("awburst", m_axi_awburst, 1);
    check("wstrb", m_axi_wstrb, {64{1'b1}});
    repeat (3) @(negedge aclk);
    arest = 0;

    run_frame(32'h1000_0000, 32'h1000_0000);
    check("f1_first_aw", first_aw, 32'h1000_0000);
    frame_checks("f1", 2'b00);

    clear_counters();
    stall_beat = 7; stall_left = 5; inject = 1; bad_burst = 3;
    run_frame(32'h1000_0000, 32'h1000_0000);
    check("f2_stall_done", stall_left, 0);
    frame_checks("f2", 2'b11);

    clear_counters();
    stall_beat = -1; inject = 0; bad_burst = -1;
    start_base = 32'h1000_0000; exp_base = 32'h1000_0000; start_req = 1;
    repeat (3) cycle();
    start_base = 32'h5555_5400; start_req = 1;
    repeat (2) cycle();
    check("busy_restart_res_start", res_start, 0);
    for (int i = 0; i < 200 && nw < 3; i++) cycle();
    check("f3_beats_before_rst", nw, 3);
    check("f3_aw_before_rst", {naw[7:0], first_aw}, {8'd1, 32'h1000_0000});
    check("f3_in_w", {busy, m_axi_awvalid, m_axi_bready}, 3'b100);
    arest = 1;
    #1;
    check("midrst_outputs", {res_start, w_handshake, wr_done, busy, m_axi_awvalid,
                             m_axi_wvalid, m_axi_wlast, m_axi_bready, err}, 0);
    check("midrst_wdata", m_axi_wdata, 0);
    clear_counters();
    res_data_valid = 0;
    repeat (3) cycle();
    @(negedge aclk);
    arest = 0;
    clear_counters();
    run_frame(32'hFFFF_03FF, 32'hFFFF_0000);
    check("f4_first_aw", first_aw, 32'hFFFF_0000);
    frame_checks("f4", 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
